// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between NREQ requesters.
// Each transfer runs setup, waits for SPI_done or a timeout, then holds a deselect gap.
module spi_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_cmd,
    input  logic [3*NREQ-1:0]    req_ss,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [15:0]          rdata,
    output logic [15:0]          SPI_cmd,
    output logic                 wrt_SPI,
    input  logic                 SPI_done,
    input  logic [15:0]          SPI_data_out,
    output logic [2:0]           ss
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAX1 = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int MAXC = (MAX1 > GAP_CYC) ? MAX1 : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            wrt_q, wrt_d;
    logic [2:0]      ss_q, ss_d;

    logic [PW-1:0]   win;
    int              idx;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win = ptr_q;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) win = PW'(idx);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
        wrt_d   = 1'b0;
        ss_d    = ss_q;

        unique case (state_q)
            IDLE: begin
                ss_d  = 3'b111;
                gnt_d = '0;
                if (|req) begin
                    sel_d   = win;
                    cmd_d   = req_cmd[16*win +: 16];
                    ss_d    = req_ss[3*win +: 3];
                    gnt_d   = NREQ'(1) << win;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (wrt_q) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    wrt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (SPI_done || cnt_q == CW'(TIMEOUT - 1)) begin
                    done_d  = gnt_q;
                    err_d   = ~SPI_done;
                    gnt_d   = '0;
                    ss_d    = 3'b111;
                    ptr_d   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                    if (SPI_done) rdata_d = SPI_data_out;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cmd_q   <= '0;
            wrt_q   <= 1'b0;
            ss_q    <= 3'b111;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cmd_q   <= cmd_d;
            wrt_q   <= wrt_d;
            ss_q    <= ss_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign SPI_cmd = cmd_q;
    assign wrt_SPI = wrt_q;
    assign ss      = ss_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level round-robin model.
module tb_spi_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int SETUP_CYC = 2;
    localparam int GAP_CYC   = 4;
    localparam int TIMEOUT   = 1024;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  req_cmd;
    logic [3*NREQ-1:0]   req_ss;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [15:0]         rdata;
    logic [15:0]         SPI_cmd;
    logic                wrt_SPI;
    logic                SPI_done;
    logic [15:0]         SPI_data_out;
    logic [2:0]          ss;

    spi_bus_arbiter #(
        .NREQ(NREQ), .SETUP_CYC(SETUP_CYC),
        .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_cmd(req_cmd), .req_ss(req_ss),
        .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .SPI_cmd(SPI_cmd),
        .wrt_SPI(wrt_SPI), .SPI_done(SPI_done),
        .SPI_data_out(SPI_data_out), .ss(ss)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          ptr_m = 0;
    logic [15:0] rdata_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic check_reset_vals();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_cmd", SPI_cmd, 0);
        chk("rst_wrt", wrt_SPI, 0);
        chk("rst_ss", ss, 3'b111);
    endtask

    // d = WAIT cycle on which SPI_done is raised (0 = never).
    task automatic xfer(input int d, input logic [15:0] data, input bit keep,
                        input int rst_at, input bit mid_change);
        int          w;
        int          k;
        int          kd;
        bit          got;
        logic [15:0] ecmd;
        logic [2:0]  ess;
        w = pick(req, ptr_m);
        chk("req_nonzero", (w >= 0), 1);
        if (w < 0) return;
        ecmd = req_cmd[16*w +: 16];
        ess  = req_ss[3*w +: 3];
        got  = 0;
        for (int i = 0; i < GAP_CYC + 10 && !got; i++) begin
            @(negedge clk);
            if (gnt !== '0) got = 1;
            else SPI_done = 1'($urandom_range(0, 1));
        end
        chk("grant_seen", got, 1);
        if (!got) return;
        chk("gnt", gnt, 1 << w);
        chk("ss_latch", ss, ess);
        chk("cmd_latch", SPI_cmd, ecmd);
        chk("wrt_early", wrt_SPI, 0);
        for (int n = 1; n <= SETUP_CYC; n++) begin
            SPI_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wrt_setup", wrt_SPI, (n == SETUP_CYC));
            chk("ss_setup", ss, ess);
        end
        got = 0;
        for (k = 1; k <= TIMEOUT + 3; k++) begin
            @(negedge clk);
            if (k == 1) chk("wrt_pulse", wrt_SPI, 0);
            if (done !== '0) begin
                got = 1;
                break;
            end
            if (rst_at == k) begin
                rst = 1'b1;
                SPI_done = 1'b0;
                req = '0;
                @(negedge clk);
                check_reset_vals();
                rst = 1'b0;
                ptr_m = 0;
                rdata_m = '0;
                return;
            end
            if (mid_change && k == 2) begin
                for (int i = 0; i < NREQ; i++) begin
                    req_cmd[16*i +: 16] = 16'($urandom);
                    req_ss[3*i +: 3] = 3'($urandom);
                end
            end
            if (mid_change && k == 3) begin
                chk("cmd_hold", SPI_cmd, ecmd);
                chk("ss_hold", ss, ess);
            end
            SPI_done = (k == d);
            SPI_data_out = (k == d) ? data : 16'($urandom);
        end
        SPI_done = 1'b0;
        chk("done_seen", got, 1);
        if (!got) return;
        kd = (d > 0 && d <= TIMEOUT) ? d + 1 : TIMEOUT + 1;
        if (d > 0 && d <= TIMEOUT) rdata_m = data;
        chk("done_time", k, kd);
        chk("done", done, 1 << w);
        chk("err", err, (d == 0));
        chk("rdata", rdata, rdata_m);
        chk("gnt_clr", gnt, 0);
        chk("ss_clr", ss, 3'b111);
        ptr_m = (w + 1) % NREQ;
        if (!keep) req[w] = 1'b0;
        for (int g = 1; g < GAP_CYC; g++) begin
            SPI_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("gap_ss", ss, 3'b111);
            chk("gap_gnt", gnt, 0);
            chk("gap_done", done, 0);
        end
        SPI_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        SPI_done = 1'b0;
        SPI_data_out = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_cmd[16*i +: 16] = 16'($urandom);
            req_ss[3*i +: 3] = 3'($urandom);
        end
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // fairness with all requesters held high
        req = 4'b1111;
        for (int i = 0; i < 5; i++) xfer(5, 16'($urandom), 1, 0, 0);

        // single transfer on requester 1
        req = 4'b0010;
        req_cmd[16 +: 16] = 16'hA55A;
        req_ss[3 +: 3] = 3'b001;
        xfer(3, 16'h00C3, 0, 0, 0);

        // timeout, then done/timeout collision
        req = 4'b0100;
        xfer(0, 16'h1234, 0, 0, 0);
        req = 4'b0100;
        xfer(TIMEOUT, 16'h5AA5, 0, 0, 0);

        // stray SPI_done while idle
        req = '0;
        for (int i = 0; i < 6; i++) begin
            SPI_done = 1'(i % 2);
            @(negedge clk);
            chk("idle_done", done, 0);
            chk("idle_gnt", gnt, 0);
            chk("idle_wrt", wrt_SPI, 0);
        end
        SPI_done = 1'b0;

        // inputs change mid-WAIT
        req = 4'b0001;
        xfer(8, 16'hBEEF, 0, 0, 1);

        // reset during WAIT, then pointer restarts at 0 and wraps
        req = 4'b0010;
        xfer(50, 16'h0000, 0, 4, 0);
        req = 4'b1000;
        xfer(4, 16'h7777, 0, 0, 0);
        req = 4'b1010;
        xfer(2, 16'h8888, 0, 0, 0);
        req = '0;

        for (int t = 0; t < 40; t++) begin
            if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            xfer($urandom_range(1, 20), 16'($urandom),
                 ($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
